// File: rtl/gpr_write_back_unit_pkg.sv
// ---------------------------------------------------------------------------
// gpr_write_back_unit_pkg
//
// Shared types for the GPR write-back path.
//   cond_exception_t : CR0 field plus the XER summary/overflow/carry bits
//                      that accompany every integer result on its way to the
//                      condition/XER unit.
// ---------------------------------------------------------------------------
package gpr_write_back_unit_pkg;

    typedef struct packed {
        logic [3:0] cr0;  // LT, GT, EQ, SO
        logic       so;   // XER summary overflow
        logic       ov;   // XER overflow
        logic       ca;   // XER carry
    } cond_exception_t;

endpackage : gpr_write_back_unit_pkg

// File: rtl/gpr_write_back_unit_if.sv
// ---------------------------------------------------------------------------
// gpr_write_back_unit_if
//
// Result hand-off from the GPR write-back arbiter to the write-back unit.
//   wb_valid    : arbiter has a result this cycle
//   wb_ready    : write-back unit can take it
//   wb_rs_id    : tag of the producing reservation station
//   wb_reg_addr : destination GPR
//   wb_result   : 32-bit result value
//   wb_cr0_xer  : CR0/XER update payload
// Modports:
//   master : arbiter side (drives the result, observes ready)
//   slave  : write-back unit side
// ---------------------------------------------------------------------------
interface gpr_write_back_unit_if
    import gpr_write_back_unit_pkg::*;
#(
    parameter int RS_ID_WIDTH = 5
);

    logic                   wb_valid;
    logic                   wb_ready;
    logic [RS_ID_WIDTH-1:0] wb_rs_id;
    logic [4:0]             wb_reg_addr;
    logic [31:0]            wb_result;
    cond_exception_t        wb_cr0_xer;

    modport master (
        output wb_valid,
        output wb_rs_id,
        output wb_reg_addr,
        output wb_result,
        output wb_cr0_xer,
        input  wb_ready
    );

    modport slave (
        input  wb_valid,
        input  wb_rs_id,
        input  wb_reg_addr,
        input  wb_result,
        input  wb_cr0_xer,
        output wb_ready
    );

endinterface : gpr_write_back_unit_if

// File: rtl/gpr_write_back_unit.sv
// ---------------------------------------------------------------------------
// gpr_write_back_unit
//
// Commits results from the GPR write-back arbiter into the 32x32 GPR file,
// retires the destination's busy/tag scoreboard entry, rebroadcasts the
// result on a registered common data bus (CDB) and forwards the CR0/XER
// payload. Dispatch claims destinations here and reads operands through
// combinational read ports.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   wb              : arbiter result channel (slave modport)
//   disp_valid      : dispatch claims disp_reg_addr for producer disp_rs_id
//   disp_reg_addr   : claimed GPR
//   disp_rs_id      : tag of the new producer
//   flush           : clear every busy bit
//   rd_addr         : per read port operand address
//   rd_data/busy/tag: per read port value, pending flag, producer tag
//   cdb_*           : registered result broadcast, one cycle after accept
//   cr_valid        : CR/XER update strobe, same timing as cdb_valid
//   cr0_xer_out     : CR/XER payload, forwarded unmodified
//
// Build option:
//   GPR_WB_BYPASS_EN : when defined, a read that hits the register being
//                      written in the accept cycle returns the incoming
//                      result and the post-edge scoreboard state. When
//                      undefined, reads see only pre-edge stored state.
// ---------------------------------------------------------------------------
module gpr_write_back_unit
    import gpr_write_back_unit_pkg::*;
#(
    parameter int RS_ID_WIDTH    = 5,
    parameter int NUM_READ_PORTS = 3
) (
    input  logic                   clk,
    input  logic                   rst,

    gpr_write_back_unit_if.slave   wb,

    input  logic                   disp_valid,
    input  logic [4:0]             disp_reg_addr,
    input  logic [RS_ID_WIDTH-1:0] disp_rs_id,
    input  logic                   flush,

    input  logic [4:0]             rd_addr [NUM_READ_PORTS],
    output logic [31:0]            rd_data [NUM_READ_PORTS],
    output logic                   rd_busy [NUM_READ_PORTS],
    output logic [RS_ID_WIDTH-1:0] rd_tag  [NUM_READ_PORTS],

    output logic                   cdb_valid,
    output logic [RS_ID_WIDTH-1:0] cdb_rs_id,
    output logic [4:0]             cdb_reg_addr,
    output logic [31:0]            cdb_result,

    output logic                   cr_valid,
    output cond_exception_t        cr0_xer_out
);

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0]      gpr_q [NUM_REGS];
    logic [DATA_W-1:0]      gpr_d [NUM_REGS];
    logic [NUM_REGS-1:0]    busy_q;
    logic [NUM_REGS-1:0]    busy_d;
    logic [RS_ID_WIDTH-1:0] tag_q [NUM_REGS];
    logic [RS_ID_WIDTH-1:0] tag_d [NUM_REGS];

    logic                   cdb_valid_q,    cdb_valid_d;
    logic [RS_ID_WIDTH-1:0] cdb_rs_id_q,    cdb_rs_id_d;
    logic [4:0]             cdb_reg_addr_q, cdb_reg_addr_d;
    logic [DATA_W-1:0]      cdb_result_q,   cdb_result_d;
    logic                   cr_valid_q,     cr_valid_d;
    cond_exception_t        cr0_xer_q,      cr0_xer_d;

    logic                   accept;
    logic                   wb_owns_dest;

    // Write-back never stalls; the only time it is refused is during reset.
    assign wb.wb_ready = ~rst;
    assign accept      = wb.wb_valid & ~rst;

    // The accepted result only retires the claim it was issued against. A
    // stale producer (destination re-claimed since it issued) still writes
    // the architectural value but must not clear the newer claim.
    assign wb_owns_dest = busy_q[wb.wb_reg_addr] &&
                          (tag_q[wb.wb_reg_addr] == wb.wb_rs_id);

    // -----------------------------------------------------------------------
    // Register file and scoreboard next state
    // -----------------------------------------------------------------------
    always_comb begin
        gpr_d  = gpr_q;
        busy_d = busy_q;
        tag_d  = tag_q;

        if (accept) begin
            gpr_d[wb.wb_reg_addr] = wb.wb_result;
            if (wb_owns_dest) begin
                busy_d[wb.wb_reg_addr] = 1'b0;
            end
        end

        // Ordering encodes priority: a same-edge dispatch to the register
        // being retired wins over the clear above.
        if (disp_valid) begin
            busy_d[disp_reg_addr] = 1'b1;
            tag_d[disp_reg_addr]  = disp_rs_id;
        end

        // Flush drops every claim, including one dispatched this edge. The
        // data write and broadcast of a same-edge accept are unaffected.
        if (flush) begin
            busy_d = '0;
        end
    end

    // -----------------------------------------------------------------------
    // CDB / CR broadcast next state
    // -----------------------------------------------------------------------
    always_comb begin
        cdb_valid_d    = accept;
        cdb_rs_id_d    = cdb_rs_id_q;
        cdb_reg_addr_d = cdb_reg_addr_q;
        cdb_result_d   = cdb_result_q;
        cr_valid_d     = accept;
        cr0_xer_d      = cr0_xer_q;

        if (accept) begin
            cdb_rs_id_d    = wb.wb_rs_id;
            cdb_reg_addr_d = wb.wb_reg_addr;
            cdb_result_d   = wb.wb_result;
            cr0_xer_d      = wb.wb_cr0_xer;
        end
    end

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q         <= '0;
            cdb_valid_q    <= 1'b0;
            cdb_rs_id_q    <= '0;
            cdb_reg_addr_q <= '0;
            cdb_result_q   <= '0;
            cr_valid_q     <= 1'b0;
            cr0_xer_q      <= '0;
        end else begin
            gpr_q          <= gpr_d;
            tag_q          <= tag_d;
            busy_q         <= busy_d;
            cdb_valid_q    <= cdb_valid_d;
            cdb_rs_id_q    <= cdb_rs_id_d;
            cdb_reg_addr_q <= cdb_reg_addr_d;
            cdb_result_q   <= cdb_result_d;
            cr_valid_q     <= cr_valid_d;
            cr0_xer_q      <= cr0_xer_d;
        end
    end

    assign cdb_valid    = cdb_valid_q;
    assign cdb_rs_id    = cdb_rs_id_q;
    assign cdb_reg_addr = cdb_reg_addr_q;
    assign cdb_result   = cdb_result_q;
    assign cr_valid     = cr_valid_q;
    assign cr0_xer_out  = cr0_xer_q;

    // -----------------------------------------------------------------------
    // Dispatch read ports
    // -----------------------------------------------------------------------
    always_comb begin
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            rd_data[p] = gpr_q[rd_addr[p]];
            rd_busy[p] = busy_q[rd_addr[p]];
            rd_tag[p]  = tag_q[rd_addr[p]];
`ifdef GPR_WB_BYPASS_EN
            // Bypass the result being committed this cycle and report the
            // scoreboard as it will look after the edge, so the consumer
            // neither waits on a producer that is retiring now nor misses a
            // claim made in the same cycle.
            if (accept && (rd_addr[p] == wb.wb_reg_addr)) begin
                rd_data[p] = wb.wb_result;
                rd_busy[p] = busy_d[rd_addr[p]];
                rd_tag[p]  = tag_d[rd_addr[p]];
            end
`endif
        end
    end

endmodule : gpr_write_back_unit
